// File: rtl/amdc_pwm_gen_pkg.sv
// rtl/amdc_pwm_gen_pkg.sv - shared widths, enums and leg-slice helper for the triangle PWM generator
package amdc_pwm_gen_pkg;

  localparam int N_LEGS_DEF = 3;
  localparam int CNT_W_DEF  = 16;
  localparam int DIV_W_DEF  = 8;
  localparam int DT_W_DEF   = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    LEG_LO = 1'b0,
    LEG_HI = 1'b1
  } leg_state_e;

  function automatic int leg_lsb(input int leg, input int width);
    return leg * width;
  endfunction

endpackage

// File: rtl/amdc_pwm_tri_gen_if.sv
// rtl/amdc_pwm_tri_gen_if.sv - configuration and gate-output bundle of the triangle PWM generator
interface amdc_pwm_tri_gen_if
  import amdc_pwm_gen_pkg::*;
#(
  parameter int N_LEGS = N_LEGS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int DT_W   = DT_W_DEF
);
  logic                    enable;
  logic [CNT_W-1:0]        carrier_max;
  logic [DIV_W-1:0]        carrier_div;
  logic [N_LEGS*CNT_W-1:0] duty;
  logic [DT_W-1:0]         deadtime;
  logic [N_LEGS-1:0]       pwm_hi;
  logic [N_LEGS-1:0]       pwm_lo;
  logic [CNT_W-1:0]        carrier_cnt;
  logic                    carrier_valley;
  logic                    carrier_peak;

  modport master (
    output enable, carrier_max, carrier_div, duty, deadtime,
    input  pwm_hi, pwm_lo, carrier_cnt, carrier_valley, carrier_peak
  );

  modport slave (
    input  enable, carrier_max, carrier_div, duty, deadtime,
    output pwm_hi, pwm_lo, carrier_cnt, carrier_valley, carrier_peak
  );
endinterface

// File: rtl/amdc_pwm_deadtime_leg.sv
// rtl/amdc_pwm_deadtime_leg.sv - one half-bridge leg: turns a raw compare into non-overlapping hi/lo gates
module amdc_pwm_deadtime_leg
  import amdc_pwm_gen_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_act,
  output logic            pwm_hi,
  output logic            pwm_lo
);

  leg_state_e      state;
  logic [DT_W-1:0] gap_cnt;
  logic            en_q;
  logic            changed;

  // The first enabled cycle is handled like a transition out of both-off.
  assign changed = !en_q || (raw != (state == LEG_HI));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= LEG_LO;
      gap_cnt <= '0;
      en_q    <= 1'b0;
      pwm_hi  <= 1'b0;
      pwm_lo  <= 1'b0;
    end else if (!en) begin
      state   <= LEG_LO;
      gap_cnt <= '0;
      en_q    <= 1'b0;
      pwm_hi  <= 1'b0;
      pwm_lo  <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (changed) begin
        state   <= raw ? LEG_HI : LEG_LO;
        gap_cnt <= dt_act;
        pwm_hi  <= raw && (dt_act == '0);
        pwm_lo  <= !raw && (dt_act == '0);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - DT_W'(1);
        if (gap_cnt == DT_W'(1)) begin
          pwm_hi <= (state == LEG_HI);
          pwm_lo <= (state == LEG_LO);
        end
      end
    end
  end

endmodule

// File: rtl/amdc_pwm_tri_gen.sv
// rtl/amdc_pwm_tri_gen.sv - shared up/down triangle carrier with prescaler, shadowed duty compare and per-leg dead-time
module amdc_pwm_tri_gen
  import amdc_pwm_gen_pkg::*;
#(
  parameter int N_LEGS = N_LEGS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int DT_W   = DT_W_DEF
) (
  input logic               ACLK,
  input logic               ARESETN,
  amdc_pwm_tri_gen_if.slave bus
);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  max_act;
  logic [CNT_W-1:0]  duty_act [N_LEGS];
  logic [DT_W-1:0]   dt_act;
  dir_e              dir;
  logic              valley;
  logic              peak;
  logic [N_LEGS-1:0] raw;
  logic [N_LEGS-1:0] pwm_hi_w;
  logic [N_LEGS-1:0] pwm_lo_w;
  logic              tick;
  logic              step_valley;
  logic              load_shadow;
  logic              leg_en;

  // >= keeps the prescaler from running past a divide value lowered mid-count.
  assign tick        = (div_cnt >= bus.carrier_div);
  assign step_valley = tick && (dir == DIR_DOWN) && (cnt == CNT_W'(1));
  assign load_shadow = !bus.enable || (tick && ((max_act == '0) || step_valley));
  assign leg_en      = bus.enable && (max_act != '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_cnt <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
      valley  <= 1'b0;
      peak    <= 1'b0;
    end else if (!bus.enable) begin
      div_cnt <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
      valley  <= 1'b0;
      peak    <= 1'b0;
    end else begin
      valley  <= 1'b0;
      peak    <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick && (max_act != '0)) begin
        if (dir == DIR_UP) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt + CNT_W'(1) == max_act) begin
            dir  <= DIR_DOWN;
            peak <= 1'b1;
          end
        end else begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            dir    <= DIR_UP;
            valley <= 1'b1;
          end
        end
      end
    end
  end

  // Shadows only move while halted or as the carrier lands on zero, so a period never mixes settings.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      max_act <= '0;
      dt_act  <= '0;
      for (int k = 0; k < N_LEGS; k++) duty_act[k] <= '0;
    end else if (load_shadow) begin
      max_act <= bus.carrier_max;
      dt_act  <= bus.deadtime;
      for (int k = 0; k < N_LEGS; k++) duty_act[k] <= bus.duty[leg_lsb(k, CNT_W) +: CNT_W];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      raw <= '0;
    end else begin
      for (int k = 0; k < N_LEGS; k++) raw[k] <= (cnt < duty_act[k]);
    end
  end

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    amdc_pwm_deadtime_leg #(.DT_W(DT_W)) u_leg (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .en      (leg_en),
      .raw     (raw[k]),
      .dt_act  (dt_act),
      .pwm_hi  (pwm_hi_w[k]),
      .pwm_lo  (pwm_lo_w[k])
    );
  end

  assign bus.pwm_hi         = pwm_hi_w;
  assign bus.pwm_lo         = pwm_lo_w;
  assign bus.carrier_cnt    = cnt;
  assign bus.carrier_valley = valley;
  assign bus.carrier_peak   = peak;

endmodule

// File: doc/amdc_pwm_tri_gen.md
Name: amdc_pwm_tri_gen

Overview:
Triangle-carrier PWM generator that produces the complementary per-leg gate signals consumed by amdc_pwm_mux.
It contains one shared up/down carrier counter with a prescaler, and per-leg duty compare with shadowed duty registers.
Each leg has dead-time insertion between its high-side and low-side outputs.
Configuration inputs are driven from the AXI4-Lite register block in the same IP; outputs go directly into the mux inputs.

Parameters:
N_LEGS, 3, number of half-bridge legs
CNT_W, 16, carrier counter / duty width
DIV_W, 8, prescaler divide-value width
DT_W, 8, dead-time width (ACLK cycles)

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
enable  in  1  run control; low = carrier halted, outputs off
carrier_max  in  CNT_W  triangle peak value
carrier_div  in  DIV_W  prescaler; carrier steps every carrier_div+1 clocks
duty  in  N_LEGS*CNT_W  per-leg compare values, leg k at [k*CNT_W +: CNT_W]
deadtime  in  DT_W  dead-time in ACLK cycles
pwm_hi  out  N_LEGS  high-side gate per leg
pwm_lo  out  N_LEGS  low-side gate per leg
carrier_cnt  out  CNT_W  current carrier value
carrier_valley  out  1  1-clock pulse when carrier reaches 0
carrier_peak  out  1  1-clock pulse when carrier reaches max

Behaviour:
- Reset (ARESETN=0, asynchronous): all outputs 0. Counters 0, direction up, shadow registers 0, dead-time counters 0.
- Prescaler: div_cnt counts 0..carrier_div and emits tick on the wrap. With carrier_div=0, tick fires every clock.
- Carrier stepping on tick:
  - Up: cnt+1; when cnt reaches max_act, direction becomes down.
  - Down: cnt-1; when cnt reaches 0, direction becomes up.
  - Sequence 0,1..max,max-1..1,0; period 2*max_act ticks.
- carrier_valley / carrier_peak: pulse in the clock cnt is registered to 0 / max_act on a tick.
- Shadowing: max_act, duty_act[k] and dt_act load from the inputs:
  - while enable=0 (every clock);
  - on each tick that lands cnt on 0.
  - Mid-period input changes have no effect until the next valley.
- max_act=0: cnt held at 0, no peak/valley pulses, all pwm_hi/pwm_lo = 0.
- Compare (per leg, registered, 1 clock after cnt): raw_k = (cnt < duty_act[k]).
  - duty=0 gives raw always 0.
  - duty>max_act gives raw always 1.
- Dead-time (per leg, sub-module):
  - The off-going output falls 1 clock after raw changes.
  - The on-going output rises exactly dt_act clocks after the off-going output falls; both are low during the gap.
  - If raw reverts before the gap ends, the gap counter reloads and no glitch pulse appears on either output.
  - dt_act=0: pwm_hi=raw and pwm_lo=~raw, with 1 clock latency.
- Invariant: pwm_hi & pwm_lo is never 1 on any leg in any cycle, including reset release and enable edges.
- enable falling: next clock, cnt, div_cnt and dead-time counters clear, direction up, all pwm outputs 0.
- enable rising: counting starts from cnt=0 with direction up. Legs treat the previous state as both-off, so the first asserted output waits dt_act clocks.
- Width rules: unsigned compares throughout; no arithmetic overflow, since cnt never exceeds max_act.

Decomposition:
- Shared package amdc_pwm_gen_pkg holds:
  - default widths;
  - the carrier direction enum (DIR_UP, DIR_DOWN);
  - the leg-slice helper function.
- One sub-module, amdc_pwm_deadtime_leg: raw in, dt_act in, pwm_hi/pwm_lo out, owning its gap counter and a two-state on/off tracking FSM. Instantiated N_LEGS times via generate.

Test Plan:
1. max=4, div=0, D=0, duty=2, enable=1 -> cnt repeats 0,1,2,3,4,3,2,1; period 8 clocks. pwm_hi high 3 of 8 clocks; pwm_lo its complement; one valley pulse and one peak pulse per period.
2. duty=0 on leg0, duty=5 on leg1 (max=4) -> leg0 pwm_hi never high and pwm_lo constant 1; leg1 pwm_hi constant 1 after the first dead-time.
3. max=10, duty=5, D=3 -> every edge shows exactly 3 clocks with both outputs low; pwm_hi & pwm_lo never 1 (continuous assertion).
4. duty changed 5->8 when cnt=6 going up -> old compare holds until cnt returns to 0; new duty applies from that valley.
5. div=1, max=4 -> cnt changes every 2 clocks; period 16 clocks; valley pulse every 16 clocks.
6. ARESETN pulled low mid-period -> all outputs 0 immediately, without waiting for a clock. Separately, enable dropped -> outputs 0 next clock; re-enable restarts at cnt=0 with a D-clock delay before the first output asserts.
